y86_imem_encoder: RTL and testbench



---
 rtl/y86_imem_encoder.sv | 129 ++++++++++++
 tb/tb_y86_imem_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/y86_imem_encoder.sv
// Serialises one decoded Y86-64 instruction per handshake into a byte-wide memory write stream.
// Optional Y86_ENC_HALT_LOCK_EN: after a halt completes, in_ready stays low until rst.
module y86_imem_encoder #(
    parameter int          MEM_BYTES = 65,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        instr_done,
    output logic [63:0] instr_pc,
    output logic [63:0] next_pc,
    output logic        err_invalid,
    output logic        err_overflow
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q;
    logic [3:0]  len_q;
    logic [3:0]  idx;
    logic [3:0]  len_in;
    logic [3:0]  const_off;
    logic [2:0]  const_sel;
    logic [7:0]  cur_byte;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h7, 4'h8:             instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            default:                instr_len = 4'd0;
        endcase
    endfunction

    assign len_in = instr_len(icode);

    // Constant bytes start after the opcode (9-byte forms) or after the register byte (10-byte forms).
    always_comb begin
        const_off = (len_q == 4'd10) ? 4'd2 : 4'd1;
        const_sel = 3'(idx - const_off);
        cur_byte  = valc_q[{const_sel, 3'b000} +: 8];
        if (idx == 4'd0)
            cur_byte = {icode_q, ifun_q};
        else if (idx == 4'd1 && (len_q == 4'd2 || len_q == 4'd10))
            cur_byte = {ra_q, rb_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= 64'd0;
            wr_data      <= 8'd0;
            instr_done   <= 1'b0;
            instr_pc     <= 64'd0;
            next_pc      <= BASE_ADDR;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
            icode_q      <= 4'd0;
            ifun_q       <= 4'd0;
            ra_q         <= 4'd0;
            rb_q         <= 4'd0;
            valc_q       <= 64'd0;
            len_q        <= 4'd0;
            idx          <= 4'd0;
        end else begin
            wr_en        <= 1'b0;
            instr_done   <= 1'b0;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (icode >= 4'hC) begin
                            err_invalid <= 1'b1;
                        // 65-bit compare so a huge next_pc can never wrap past the check
                        end else if (({1'b0, next_pc} + 65'(len_in)) > 65'(MEM_BYTES)) begin
                            err_overflow <= 1'b1;
                        end else begin
                            icode_q  <= icode;
                            ifun_q   <= ifun;
                            ra_q     <= (icode == 4'h3) ? 4'hF : rA;
                            rb_q     <= (icode == 4'hA || icode == 4'hB) ? 4'hF : rB;
                            valc_q   <= valC;
                            len_q    <= len_in;
                            idx      <= 4'd0;
                            in_ready <= 1'b0;
                            state    <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    wr_en   <= 1'b1;
                    wr_addr <= next_pc + 64'(idx);
                    wr_data <= cur_byte;
                    if (idx == len_q - 4'd1) begin
                        instr_done <= 1'b1;
                        instr_pc   <= next_pc;
                        next_pc    <= next_pc + 64'(len_q);
                        state      <= IDLE;
`ifdef Y86_ENC_HALT_LOCK_EN
                        in_ready   <= (icode_q != 4'h0);
`else
                        in_ready   <= 1'b1;
`endif
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Directed plan steps plus random instruction streams checked against a byte-list reference model.
module tb_y86_imem_encoder;

    localparam int MEM = 65;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = 4'd0, ifun = 4'd0, ra = 4'd0, rb = 4'd0;
    logic [63:0] valc = 64'd0;
    logic        wr_en, instr_done, err_invalid, err_overflow;
    logic [63:0] wr_addr, instr_pc, next_pc;
    logic [7:0]  wr_data;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] model_pc = 64'd0;

    y86_imem_encoder #(.MEM_BYTES(MEM), .BASE_ADDR(64'd0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(ra), .rB(rb), .valC(valc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .instr_done(instr_done), .instr_pc(instr_pc), .next_pc(next_pc),
        .err_invalid(err_invalid), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_instr_done", instr_done, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_next_pc", next_pc, 0);
        chk("rst_err_invalid", err_invalid, 0);
        chk("rst_err_overflow", err_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        model_pc = 64'd0;
    endtask

    task automatic do_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                            input logic [3:0] b, input logic [63:0] c);
        int         len;
        logic [7:0] exp_q[$];
        logic       exp_ready;
        len = ref_len(ic);
        @(negedge clk);
        chk("ready_before", in_ready, 1);
        icode = ic; ifun = fn; ra = a; rb = b; valc = c; in_valid = 1'b1;
        @(posedge clk); #1;
        // scramble the inputs: the encoder must work from its latched copy
        in_valid = 1'b0;
        icode = 4'($urandom); ifun = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
        valc = {$urandom, $urandom};
        if (ic >= 4'hC) begin
            chk("inv_pulse", err_invalid, 1);
            chk("inv_no_wr", wr_en, 0);
            chk("inv_ready", in_ready, 1);
            chk("inv_next_pc", next_pc, model_pc);
            @(posedge clk); #1;
            chk("inv_pulse_end", err_invalid, 0);
            return;
        end
        if (model_pc + 64'(len) > 64'(MEM)) begin
            chk("ovf_pulse", err_overflow, 1);
            chk("ovf_no_wr", wr_en, 0);
            chk("ovf_ready", in_ready, 1);
            chk("ovf_next_pc", next_pc, model_pc);
            @(posedge clk); #1;
            chk("ovf_pulse_end", err_overflow, 0);
            return;
        end
        chk("acc_ready_low", in_ready, 0);
        chk("acc_no_wr_yet", wr_en, 0);
        chk("acc_no_err", {err_invalid, err_overflow}, 0);
        exp_q.push_back({ic, fn});
        if (len == 2 || len == 10)
            exp_q.push_back({(ic == 4'h3) ? 4'hF : a, (ic == 4'hA || ic == 4'hB) ? 4'hF : b});
        if (len >= 9)
            for (int k = 0; k < 8; k++) exp_q.push_back(8'((c >> (8 * k)) & 64'hFF));
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            chk("byte_wr_en", wr_en, 1);
            chk("byte_addr", wr_addr, model_pc + 64'(i));
            chk("byte_data", wr_data, exp_q[i]);
            chk("byte_done", instr_done, (i == len - 1) ? 1 : 0);
            if (i == len - 1) chk("done_instr_pc", instr_pc, model_pc);
        end
`ifdef Y86_ENC_HALT_LOCK_EN
        exp_ready = (ic != 4'h0);
`else
        exp_ready = 1'b1;
`endif
        chk("done_ready", in_ready, exp_ready);
        model_pc = model_pc + 64'(len);
        @(posedge clk); #1;
        chk("after_wr_en", wr_en, 0);
        chk("after_done", instr_done, 0);
        chk("after_next_pc", next_pc, model_pc);
        chk("after_ready", in_ready, exp_ready);
    endtask

    initial begin
        logic [3:0] ric;
        do_reset();

        // irmovq, OPq, pushq, jne, ret
        do_instr(4'h3, 4'h0, 4'h0, 4'h0, 64'd1);
        do_instr(4'h6, 4'h0, 4'h1, 4'h0, 64'h0);
        do_instr(4'hA, 4'h0, 4'h2, 4'h5, 64'h0);
        do_instr(4'h7, 4'h4, 4'h0, 4'h0, 64'h5A);
        do_instr(4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
        do_instr(4'hB, 4'h0, 4'h7, 4'h3, 64'h0);
        do_instr(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
        do_instr(4'hF, 4'h3, 4'h1, 4'h1, 64'h0);

        // fill to 60, overflow irmovq, exactly-full OPq at 63, then overflow nop
        do_reset();
        for (int n = 0; n < 6; n++) do_instr(4'h3, 4'h0, 4'h0, 4'($urandom), {$urandom, $urandom});
        do_instr(4'h3, 4'h0, 4'h0, 4'h1, 64'h1234);
        for (int n = 0; n < 3; n++) do_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        do_instr(4'h6, 4'h1, 4'h2, 4'h3, 64'h0);
        chk("full_next_pc", next_pc, 65);
        do_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);

        // reset in the middle of an irmovq
        do_reset();
        @(negedge clk);
        icode = 4'h3; ifun = 4'h0; ra = 4'h0; rb = 4'h2; valc = 64'hDEAD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_4th_byte_addr", wr_addr, 3);
        do_reset();
        do_instr(4'h8, 4'h0, 4'h0, 4'h0, 64'h0102030405060708);

        // halt followed by nop
        do_reset();
        do_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
`ifdef Y86_ENC_HALT_LOCK_EN
        @(negedge clk);
        icode = 4'h1; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("lock_no_wr", wr_en, 0);
            chk("lock_no_err", {err_invalid, err_overflow}, 0);
            chk("lock_ready", in_ready, 0);
            chk("lock_next_pc", next_pc, 1);
        end
        in_valid = 1'b0;
`else
        do_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
`endif

        // random streams
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (model_pc > 55 && $urandom_range(0, 2) == 0) do_reset();
            ric = 4'($urandom_range(0, 15));
            if (ric == 4'h0) ric = 4'h1;
            do_instr(ric, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
